cs_microsequencer: RTL and testbench
====================================

// Module: cs_microsequencer
// PURPOSE
//  Parametrised control-store sequencer; successor to the fixed CSAI + CS address mux + branch-logic group.
//  Each cycle it computes the next micro-PC from:
//   - the current MIR condition field and jump address;
//   - the PSR flags, IR bit 13 and the IR dispatch opcode;
//   - the memory ACK.
//  New behaviour: a micro-subroutine return stack (CALL/RET), a memory-wait stall, and sticky stack-error flags.
//  Sits between the MIR/PSR and the control-store ROM address input.
// PARAMETERS
//  ADDR_WIDTH      11  micro-PC / control-store address width
//  DISPATCH_WIDTH  8   IR opcode bits used for decode; must equal ADDR_WIDTH-3
//  STACK_DEPTH     4   return-stack entries (>=1)
//  RESET_ADDR      0   micro-PC value after reset
// PORTS
//  CS_SEQ_CLOCK_50       in   1               system clock, rising edge
//  CS_SEQ_RESET_InLow    in   1               asynchronous, active-low reset
//  CS_SEQ_clear_InLow    in   1               synchronous clear of sticky error flags
//  CS_SEQ_COND_InBUS     in   3               MIR condition field
//  CS_SEQ_OP_InBUS       in   2               MIR sequencer op: 00 NORM, 01 CALL, 10 RET, 11 = NORM
//  CS_SEQ_JUMP_InBUS     in   ADDR_WIDTH      MIR jump address
//  CS_SEQ_FLAGS_InBUS    in   4               PSR {n,z,v,c}
//  CS_SEQ_Bit13          in   1               IR[13]
//  CS_SEQ_DISPATCH_InBUS in   DISPATCH_WIDTH  {IR[31:30],IR[24:19]}
//  CS_SEQ_RD / CS_SEQ_WR in   1               MIR memory read / write request
//  CS_SEQ_ACK            in   1               main-memory acknowledge
//  CS_SEQ_UPC_OutBUS     out  ADDR_WIDTH      registered micro-PC (control-store address)
//  CS_SEQ_DEPTH_OutBUS   out  $clog2(STACK_DEPTH+1)  stack occupancy
//  CS_SEQ_WAIT_Out       out  1               combinational: stall this cycle
//  CS_SEQ_OVF_Out        out  1               sticky: CALL attempted while the stack was full
//  CS_SEQ_UNF_Out        out  1               sticky: RET attempted while the stack was empty
// BEHAVIOUR
//  Reset (async, RESET_InLow=0):
//   - UPC=RESET_ADDR, DEPTH=0, OVF=0, UNF=0, all stack entries 0; effect is immediate.
//   - Reset mid-stall or mid-CALL discards all state.
//  Next-PC update:
//   - UPC loads the next value on every rising clock edge; ROM address latency is 1 cycle.
//   - inc = UPC+1, modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
//  NORM condition decode:
//   0 inc
//   1 n ? JUMP : inc
//   2 z ? JUMP : inc
//   3 v ? JUMP : inc
//   4 c ? JUMP : inc
//   5 Bit13 ? JUMP : inc
//   6 JUMP
//   7 {1'b1, DISPATCH, 2'b00}
//  CALL: push inc, then UPC=JUMP. COND is ignored (the call is unconditional).
//  RET: pop the top entry into UPC.
//  Stack boundaries:
//   - CALL while DEPTH==STACK_DEPTH: jump still taken, push dropped, DEPTH unchanged, OVF<=1.
//   - RET while DEPTH==0: UPC=inc, UNF<=1, DEPTH stays 0.
//   - LIFO order; unused entries are don't-care.
//  Stall:
//   - WAIT = (RD|WR) & ~ACK.
//   - While WAIT=1: UPC, stack, DEPTH and sticky flags all hold.
//   - Stall has priority over CALL/RET/NORM; the op executes on the first cycle ACK=1.
//  Sticky flags:
//   - clear_InLow=0 clears OVF/UNF at the clock edge.
//   - If an error event occurs in the same cycle as the clear, the flag is set (set wins).
//  Output timing: all outputs except WAIT are registered; no combinational path from any input to UPC.
// TESTING
//  1. Reset low mid-run -> UPC=0, DEPTH=0 immediately; release, OP=NORM COND=0 x3 -> UPC 1,2,3.
//  2. Branch decode:
//     - COND=2, JUMP=0x155, z=1 -> UPC=0x155; z=0 -> UPC increments.
//     - COND=7, DISPATCH=0x81 -> UPC=0x604.
//  3. Subroutine: UPC=0x010, CALL JUMP=0x200 -> UPC=0x200, DEPTH=1; RET -> UPC=0x011, DEPTH=0.
//  4. Stack limits (STACK_DEPTH=4):
//     - 5 nested CALLs -> DEPTH=4, OVF=1, 5th jump still taken.
//     - 5 RETs -> 4 correct LIFO returns, then UNF=1 with UPC=inc.
//     - clear_InLow=0 -> OVF=UNF=0.
//  5. Memory wait: RD=1, ACK=0 for 3 cycles with OP=CALL -> WAIT=1, UPC and DEPTH frozen;
//     ACK=1 -> CALL executes once.
//  6. Wrap: UPC=0x7FF, NORM COND=0 -> UPC=0x000. Rerun tests 1-3 with ADDR_WIDTH=12, DISPATCH_WIDTH=9.

Source files
------------

// File: rtl/cs_microsequencer.sv
// Control-store micro-sequencer: computes the next micro-PC from the MIR, PSR, IR and memory ACK,
// with a micro-subroutine return stack, a memory-wait stall and sticky stack-error flags.
module cs_microsequencer #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DISPATCH_WIDTH = 8,
    parameter int STACK_DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                               CS_SEQ_CLOCK_50,
    input  logic                               CS_SEQ_RESET_InLow,
    input  logic                               CS_SEQ_clear_InLow,
    input  logic [2:0]                         CS_SEQ_COND_InBUS,
    input  logic [1:0]                         CS_SEQ_OP_InBUS,
    input  logic [ADDR_WIDTH-1:0]              CS_SEQ_JUMP_InBUS,
    input  logic [3:0]                         CS_SEQ_FLAGS_InBUS,
    input  logic                               CS_SEQ_Bit13,
    input  logic [DISPATCH_WIDTH-1:0]          CS_SEQ_DISPATCH_InBUS,
    input  logic                               CS_SEQ_RD,
    input  logic                               CS_SEQ_WR,
    input  logic                               CS_SEQ_ACK,
    output logic [ADDR_WIDTH-1:0]              CS_SEQ_UPC_OutBUS,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   CS_SEQ_DEPTH_OutBUS,
    output logic                               CS_SEQ_WAIT_Out,
    output logic                               CS_SEQ_OVF_Out,
    output logic                               CS_SEQ_UNF_Out
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;

    logic [ADDR_WIDTH-1:0] upc_q;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [DEPTH_W-1:0]    depth_q;
    logic                  ovf_q;
    logic                  unf_q;

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] next_upc;
    logic                  taken;
    logic                  do_push;
    logic                  do_pop;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic                  stall;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      top_idx;

    // Stall handshake: a MIR memory request (RD or WR) is outstanding until ACK is seen.
    // While WAIT is high nothing in the sequencer advances; the op held on the MIR executes
    // on the first cycle ACK is high, exactly once.
    assign stall = (CS_SEQ_RD | CS_SEQ_WR) & ~CS_SEQ_ACK;

    assign push_idx = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));

    always_comb begin
        inc      = upc_q + ADDR_WIDTH'(1);
        taken    = 1'b0;
        next_upc = inc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;

        unique case (CS_SEQ_COND_InBUS)
            3'd1:    taken = CS_SEQ_FLAGS_InBUS[3];
            3'd2:    taken = CS_SEQ_FLAGS_InBUS[2];
            3'd3:    taken = CS_SEQ_FLAGS_InBUS[1];
            3'd4:    taken = CS_SEQ_FLAGS_InBUS[0];
            3'd5:    taken = CS_SEQ_Bit13;
            3'd6:    taken = 1'b1;
            default: taken = 1'b0;
        endcase

        unique case (CS_SEQ_OP_InBUS)
            OP_CALL: begin
                // The jump is taken even when the return address cannot be saved.
                next_upc = CS_SEQ_JUMP_InBUS;
                if (depth_q == FULL) ovf_evt = 1'b1;
                else                 do_push = 1'b1;
            end
            OP_RET: begin
                if (depth_q == '0) begin
                    unf_evt = 1'b1;
                end else begin
                    next_upc = stack_q[top_idx];
                    do_pop   = 1'b1;
                end
            end
            default: begin
                if (CS_SEQ_COND_InBUS == 3'd7)
                    next_upc = {1'b1, CS_SEQ_DISPATCH_InBUS, 2'b00};
                else if (taken)
                    next_upc = CS_SEQ_JUMP_InBUS;
            end
        endcase
    end

    always_ff @(posedge CS_SEQ_CLOCK_50 or negedge CS_SEQ_RESET_InLow) begin
        if (!CS_SEQ_RESET_InLow) begin
            upc_q   <= RESET_ADDR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (!stall) begin
            upc_q <= next_upc;
            if (do_push) begin
                stack_q[push_idx] <= inc;
                depth_q           <= depth_q + DEPTH_W'(1);
            end else if (do_pop) begin
                depth_q <= depth_q - DEPTH_W'(1);
            end
            // An error event in the same cycle as the clear leaves the flag set.
            ovf_q <= (ovf_q & CS_SEQ_clear_InLow) | ovf_evt;
            unf_q <= (unf_q & CS_SEQ_clear_InLow) | unf_evt;
        end
    end

    assign CS_SEQ_UPC_OutBUS   = upc_q;
    assign CS_SEQ_DEPTH_OutBUS = depth_q;
    assign CS_SEQ_WAIT_Out     = stall;
    assign CS_SEQ_OVF_Out      = ovf_q;
    assign CS_SEQ_UNF_Out      = unf_q;

endmodule

// File: tb/tb_cs_microsequencer.sv
// Directed bench for cs_microsequencer: an 11-bit and a 12-bit instance share the stimulus,
// the driver queues hand-computed expected state per cycle and a monitor pops and compares.
module tb_cs_microsequencer;
    logic        clk;
    logic        rst_n;
    logic        clr_n;
    logic [2:0]  cond;
    logic [1:0]  op;
    logic [10:0] jump;
    logic [3:0]  flags;
    logic        b13;
    logic [7:0]  disp;
    logic        rd;
    logic        wr;
    logic        ack;

    logic [10:0] upc;
    logic [2:0]  depth;
    logic        wt;
    logic        ovf;
    logic        unf;
    logic [11:0] upc12;
    logic [2:0]  depth12;
    logic        wt12;
    logic        ovf12;
    logic        unf12;

    // {wait, unf, ovf, depth[2:0], upc[10:0]}
    logic [16:0] exp_q[$];
    logic [11:0] exp12_q[$];
    int          n_checks;
    int          n_fail;
    int          step_no;

    cs_microsequencer #(.ADDR_WIDTH(11), .DISPATCH_WIDTH(8), .STACK_DEPTH(4)) u_dut (
        .CS_SEQ_CLOCK_50(clk), .CS_SEQ_RESET_InLow(rst_n), .CS_SEQ_clear_InLow(clr_n),
        .CS_SEQ_COND_InBUS(cond), .CS_SEQ_OP_InBUS(op), .CS_SEQ_JUMP_InBUS(jump),
        .CS_SEQ_FLAGS_InBUS(flags), .CS_SEQ_Bit13(b13), .CS_SEQ_DISPATCH_InBUS(disp),
        .CS_SEQ_RD(rd), .CS_SEQ_WR(wr), .CS_SEQ_ACK(ack),
        .CS_SEQ_UPC_OutBUS(upc), .CS_SEQ_DEPTH_OutBUS(depth), .CS_SEQ_WAIT_Out(wt),
        .CS_SEQ_OVF_Out(ovf), .CS_SEQ_UNF_Out(unf)
    );

    cs_microsequencer #(.ADDR_WIDTH(12), .DISPATCH_WIDTH(9), .STACK_DEPTH(4)) u_dut12 (
        .CS_SEQ_CLOCK_50(clk), .CS_SEQ_RESET_InLow(rst_n), .CS_SEQ_clear_InLow(clr_n),
        .CS_SEQ_COND_InBUS(cond), .CS_SEQ_OP_InBUS(op), .CS_SEQ_JUMP_InBUS({1'b0, jump}),
        .CS_SEQ_FLAGS_InBUS(flags), .CS_SEQ_Bit13(b13), .CS_SEQ_DISPATCH_InBUS({1'b0, disp}),
        .CS_SEQ_RD(rd), .CS_SEQ_WR(wr), .CS_SEQ_ACK(ack),
        .CS_SEQ_UPC_OutBUS(upc12), .CS_SEQ_DEPTH_OutBUS(depth12), .CS_SEQ_WAIT_Out(wt12),
        .CS_SEQ_OVF_Out(ovf12), .CS_SEQ_UNF_Out(unf12)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected the driver to finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic drv(input logic [1:0] o, input logic [2:0] c, input logic [10:0] j);
        op   = o;
        cond = c;
        jump = j;
    endtask

    // Queue the expected post-edge state, let one rising edge happen, return at the falling edge.
    task automatic cyc(input logic [10:0] e_upc, input logic [11:0] e_upc12, input logic [2:0] e_dep,
                       input logic e_ovf, input logic e_unf, input logic e_wait);
        exp_q.push_back({e_wait, e_unf, e_ovf, e_dep, e_upc});
        exp12_q.push_back(e_upc12);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [16:0] e;
        logic [11:0] e12;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                e12 = exp12_q.pop_front();
                step_no++;
                n_checks++;
                if ({wt, unf, ovf, depth, upc} !== e ||
                    {wt12, unf12, ovf12, depth12, upc12} !== {e[16:11], e12}) begin
                    n_fail++;
                    $display("FAIL step%0d: got upc=%h upc12=%h depth=%0d/%0d ovf=%b/%b unf=%b/%b wait=%b/%b, expected upc=%h upc12=%h depth=%0d ovf=%b unf=%b wait=%b",
                             step_no, upc, upc12, depth, depth12, ovf, ovf12, unf, unf12, wt, wt12,
                             e[10:0], e12, e[13:11], e[14], e[15], e[16]);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        step_no  = 0;
        rst_n = 1'b0; clr_n = 1'b1;
        cond = 3'd0; op = 2'b00; jump = '0; flags = '0; b13 = 1'b0; disp = '0;
        rd = 1'b0; wr = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_upc", 32'(upc), 32'h0);
        chk("reset_depth_flags", 32'({depth, ovf, unf}), 32'h0);
        rst_n = 1'b1;

        // Sequential increments, then asynchronous reset mid-run
        cyc(11'h001, 12'h001, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(11'h002, 12'h002, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b01, 3'd0, 11'h040);
        cyc(11'h040, 12'h040, 3'd1, 1'b0, 1'b0, 1'b0);
        drv(2'b00, 3'd0, 11'h000);
        rst_n = 1'b0;
        #1;
        chk("async_reset_upc", 32'(upc), 32'h0);
        chk("async_reset_upc12", 32'(upc12), 32'h0);
        chk("async_reset_depth", 32'(depth), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(11'h001, 12'h001, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(11'h002, 12'h002, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(11'h003, 12'h003, 3'd0, 1'b0, 1'b0, 1'b0);

        // Branch decode
        drv(2'b00, 3'd2, 11'h155); flags = 4'b0100;
        cyc(11'h155, 12'h155, 3'd0, 1'b0, 1'b0, 1'b0);
        flags = 4'b1011;
        cyc(11'h156, 12'h156, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b00, 3'd1, 11'h020); flags = 4'b1000;
        cyc(11'h020, 12'h020, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b00, 3'd4, 11'h050); flags = 4'b1110;
        cyc(11'h021, 12'h021, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b00, 3'd5, 11'h030); flags = 4'b0000; b13 = 1'b1;
        cyc(11'h030, 12'h030, 3'd0, 1'b0, 1'b0, 1'b0);
        b13 = 1'b0;
        drv(2'b00, 3'd7, 11'h000); disp = 8'h81;
        cyc(11'h604, 12'hA04, 3'd0, 1'b0, 1'b0, 1'b0);
        disp = 8'h00;
        drv(2'b00, 3'd6, 11'h00F);
        cyc(11'h00F, 12'h00F, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b00, 3'd0, 11'h000);
        cyc(11'h010, 12'h010, 3'd0, 1'b0, 1'b0, 1'b0);

        // Subroutine call and return; COND is ignored on CALL
        drv(2'b01, 3'd0, 11'h200);
        cyc(11'h200, 12'h200, 3'd1, 1'b0, 1'b0, 1'b0);
        drv(2'b10, 3'd6, 11'h3FF);
        cyc(11'h011, 12'h011, 3'd0, 1'b0, 1'b0, 1'b0);

        // Five nested calls overflow a four-entry stack; the fifth jump is still taken
        drv(2'b01, 3'd0, 11'h100); cyc(11'h100, 12'h100, 3'd1, 1'b0, 1'b0, 1'b0);
        drv(2'b01, 3'd0, 11'h110); cyc(11'h110, 12'h110, 3'd2, 1'b0, 1'b0, 1'b0);
        drv(2'b01, 3'd0, 11'h120); cyc(11'h120, 12'h120, 3'd3, 1'b0, 1'b0, 1'b0);
        drv(2'b01, 3'd0, 11'h130); cyc(11'h130, 12'h130, 3'd4, 1'b0, 1'b0, 1'b0);
        drv(2'b01, 3'd0, 11'h140); cyc(11'h140, 12'h140, 3'd4, 1'b1, 1'b0, 1'b0);
        drv(2'b10, 3'd0, 11'h000);
        cyc(11'h121, 12'h121, 3'd3, 1'b1, 1'b0, 1'b0);
        cyc(11'h111, 12'h111, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc(11'h101, 12'h101, 3'd1, 1'b1, 1'b0, 1'b0);
        cyc(11'h012, 12'h012, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc(11'h013, 12'h013, 3'd0, 1'b1, 1'b1, 1'b0);

        // Sticky clear, then an underflow in the same cycle as the clear stays set
        drv(2'b00, 3'd0, 11'h000); clr_n = 1'b0;
        cyc(11'h014, 12'h014, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b10, 3'd0, 11'h000);
        cyc(11'h015, 12'h015, 3'd0, 1'b0, 1'b1, 1'b0);
        drv(2'b00, 3'd0, 11'h000);
        cyc(11'h016, 12'h016, 3'd0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;

        // Memory wait holds a pending CALL until ACK; write stall holds a RET
        drv(2'b01, 3'd0, 11'h300); rd = 1'b1; ack = 1'b0;
        repeat (3) cyc(11'h016, 12'h016, 3'd0, 1'b0, 1'b0, 1'b1);
        ack = 1'b1;
        cyc(11'h300, 12'h300, 3'd1, 1'b0, 1'b0, 1'b0);
        drv(2'b10, 3'd0, 11'h000); rd = 1'b0; wr = 1'b1; ack = 1'b0;
        cyc(11'h300, 12'h300, 3'd1, 1'b0, 1'b0, 1'b1);
        wr = 1'b0;
        cyc(11'h017, 12'h017, 3'd0, 1'b0, 1'b0, 1'b0);

        // Wrap at the top of the 11-bit space; the 12-bit instance carries on to 0x800
        drv(2'b00, 3'd6, 11'h7FF);
        cyc(11'h7FF, 12'h7FF, 3'd0, 1'b0, 1'b0, 1'b0);
        drv(2'b00, 3'd0, 11'h000);
        cyc(11'h000, 12'h800, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(11'h001, 12'h801, 3'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
